// File: rtl/mod_n_up_counter.sv
// Programmable modulo-MOD up counter: counts 0..MOD-1 and wraps.
// Supports synchronous clear, clamped parallel load and count enable.
// tc and carry are combinational so that stages can be cascaded.
// match, load_err and a saturating wrap tally are registered.
module mod_n_up_counter #(
    parameter int WIDTH = 4,
    parameter int MOD   = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] cmp_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             carry,
    output logic             match,
    output logic             load_err,
    output logic [7:0]       wrap_cnt
);

    // Reject an unusable modulus when the design is elaborated.
    if ((MOD < 2) || (MOD > (1 << WIDTH))) begin : g_mod_check
        $error("mod_n_up_counter: MOD must lie in 2..2**WIDTH");
    end

    // The modulus is handled at WIDTH+1 bits so that MOD = 2**WIDTH is representable.
    localparam logic [WIDTH:0] MOD_W    = (WIDTH+1)'(MOD);
    localparam logic [WIDTH:0] MOD_M1_W = MOD_W - {{WIDTH{1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_r;
    logic             match_r;
    logic             load_err_r;
    logic [7:0]       wrap_cnt_r;

    logic [WIDTH-1:0] count_nx_s;
    logic             match_nx_s;
    logic             load_err_nx_s;
    logic [7:0]       wrap_cnt_nx_s;
    logic [WIDTH:0]   inc_s;
    logic             tc_s;

    assign inc_s = {1'b0, count_r} + {{WIDTH{1'b0}}, 1'b1};
    assign tc_s  = ({1'b0, count_r} == MOD_M1_W);

    // Next-state selection in priority order clr > load > en > hold.
    always_comb begin
        count_nx_s    = count_r;
        wrap_cnt_nx_s = wrap_cnt_r;
        match_nx_s    = 1'b0;
        load_err_nx_s = 1'b0;
        if (clr) begin
            count_nx_s    = {WIDTH{1'b0}};
            wrap_cnt_nx_s = 8'd0;
        end else if (load) begin
            if ({1'b0, load_val} < MOD_W) begin
                count_nx_s = load_val;
            end else begin
                // Out-of-range data is clamped to the terminal value and flagged.
                count_nx_s    = MOD_M1_W[WIDTH-1:0];
                load_err_nx_s = 1'b1;
            end
        end else if (en) begin
            if (tc_s) begin
                count_nx_s = {WIDTH{1'b0}};
                if (wrap_cnt_r != 8'd255) begin
                    wrap_cnt_nx_s = wrap_cnt_r + 8'd1;
                end else begin
                    wrap_cnt_nx_s = wrap_cnt_r;
                end
            end else begin
                count_nx_s = inc_s[WIDTH-1:0];
            end
            // A compare value outside the modulus can never be reached.
            if (({1'b0, cmp_val} < MOD_W) && (count_nx_s == cmp_val)) begin
                match_nx_s = 1'b1;
            end else begin
                match_nx_s = 1'b0;
            end
        end else begin
            count_nx_s = count_r;
        end
    end

    // State register with synchronous reset overriding every other action.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r    <= {WIDTH{1'b0}};
            match_r    <= 1'b0;
            load_err_r <= 1'b0;
            wrap_cnt_r <= 8'd0;
        end else begin
            count_r    <= count_nx_s;
            match_r    <= match_nx_s;
            load_err_r <= load_err_nx_s;
            wrap_cnt_r <= wrap_cnt_nx_s;
        end
    end

    assign count    = count_r;
    assign match    = match_r;
    assign load_err = load_err_r;
    assign wrap_cnt = wrap_cnt_r;
    assign tc       = tc_s;
    assign carry    = tc_s & en & ~clr & ~load & ~rst;

endmodule
